// File: rtl/riscv_pkg.sv
// Shared pipeline types and constants for the 5-stage core.
// The IF/ID record width follows the package XLEN.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_BR   = 2'd1,
        PC_MRET = 2'd2,
        PC_TRAP = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
        logic            misalign;
    } if_id_t;

endpackage

// File: rtl/pc_sel_mux.sv
// Next-PC priority select: trap > mret > branch/jump > sequential.
// A redirect always wins over a stall.
module pc_sel_mux #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output riscv_pkg::pc_sel_e sel_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] next_pc_o
);
    import riscv_pkg::*;

    always_comb begin
        sel_o = PC_SEQ;
        if (trap_i)          sel_o = PC_TRAP;
        else if (mret_i)     sel_o = PC_MRET;
        else if (br_taken_i) sel_o = PC_BR;
    end

    assign redirect_o = (sel_o != PC_SEQ);

    always_comb begin
        next_pc_o = pc_i;
        case (sel_o)
            PC_TRAP: next_pc_o = trap_vec_i;
            PC_MRET: next_pc_o = mepc_i;
            PC_BR:   next_pc_o = br_target_i;
            default: next_pc_o = stall_i ? pc_i : pc_i + XLEN'(4);
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory address, and the IF/ID register
// with stall/flush/redirect bubbling and misaligned-target tagging.
module fetch_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_inst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_inst_o,
    output logic            id_valid_o,
    output logic            id_misalign_o
);
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    pc_sel_e         pc_sel;
    logic            redirect;
    logic            misalign;

    pc_sel_mux #(.XLEN(XLEN)) u_pc_sel (
        .pc_i        (pc_q),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .trap_i      (trap_i),
        .trap_vec_i  (trap_vec_i),
        .mret_i      (mret_i),
        .mepc_i      (mepc_i),
        .sel_o       (pc_sel),
        .redirect_o  (redirect),
        .next_pc_o   (pc_d)
    );

    assign misalign = (pc_q[1:0] != 2'b00);

    always_comb begin
        if_id_d = if_id_q;
        if (redirect || flush_i) begin
            if_id_d.pc       = pc_q;
            if_id_d.inst     = NOP_INST;
            if_id_d.valid    = 1'b0;
            if_id_d.misalign = 1'b0;
        end else if (!stall_i) begin
            // Misaligned fetches carry no usable word; the CSR path traps on the tag.
            if_id_d.pc       = pc_q;
            if_id_d.inst     = misalign ? NOP_INST : imem_inst_i;
            if_id_d.valid    = 1'b1;
            if_id_d.misalign = misalign;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q             <= RESET_PC;
            if_id_q.pc       <= '0;
            if_id_q.inst     <= NOP_INST;
            if_id_q.valid    <= 1'b0;
            if_id_q.misalign <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_pc_o       = pc_q;
    assign id_pc_o       = if_id_q.pc;
    assign id_inst_o     = if_id_q.inst;
    assign id_valid_o    = if_id_q.valid;
    assign id_misalign_o = if_id_q.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized check of fetch_stage against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_inst;
    logic        stall = 0, flush = 0, br = 0, trap = 0, mret = 0;
    logic [31:0] br_tgt = 0, trap_vec = 0, mepc = 0;
    logic [31:0] if_pc, id_pc, id_inst;
    logic        id_valid, id_mis;

    int vectors = 0;
    int miscompares = 0;

    // reference state
    logic [31:0] m_pc, m_idpc, m_idinst;
    logic        m_idv, m_idm;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1357};
    endfunction

    assign imem_inst = mem_word(imem_addr);

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_addr_o(imem_addr), .imem_inst_i(imem_inst),
        .stall_i(stall), .flush_i(flush),
        .br_taken_i(br), .br_target_i(br_tgt),
        .trap_i(trap), .trap_vec_i(trap_vec),
        .mret_i(mret), .mepc_i(mepc),
        .if_pc_o(if_pc), .id_pc_o(id_pc), .id_inst_o(id_inst),
        .id_valid_o(id_valid), .id_misalign_o(id_mis)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_idpc = 32'h0; m_idinst = NOP; m_idv = 1'b0; m_idm = 1'b0;
    endtask

    task automatic chk_model();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_pc", if_pc, m_pc);
        chk("id_pc", id_pc, m_idpc);
        chk("id_inst", id_inst, m_idinst);
        chk("id_valid", {31'b0, id_valid}, {31'b0, m_idv});
        chk("id_mis", {31'b0, id_mis}, {31'b0, m_idm});
    endtask

    // One clock: derive the next architectural state from the rules, advance, compare.
    task automatic step();
        logic [31:0] npc, nidpc, nidinst;
        logic        nv, nm, redir;
        redir = trap | mret | br;
        if (redir)      npc = trap ? trap_vec : (mret ? mepc : br_tgt);
        else if (stall) npc = m_pc;
        else            npc = m_pc + 32'd4;
        nidpc = m_idpc; nidinst = m_idinst; nv = m_idv; nm = m_idm;
        if (redir || flush) begin
            nidpc = m_pc; nidinst = NOP; nv = 1'b0; nm = 1'b0;
        end else if (!stall) begin
            nidpc = m_pc;
            nm    = (m_pc % 4) != 0;
            nidinst = nm ? NOP : mem_word(m_pc);
            nv    = 1'b1;
        end
        @(posedge clk); #1;
        m_pc = npc; m_idpc = nidpc; m_idinst = nidinst; m_idv = nv; m_idm = nm;
        chk_model();
    endtask

    task automatic idle();
        stall = 0; flush = 0; br = 0; trap = 0; mret = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_model();
        chk("reset_valid", {31'b0, id_valid}, 32'd0);
        chk("reset_inst", id_inst, NOP);
        rst_n = 1'b1;
        #1;
        chk("addr0", imem_addr, 32'h0);

        // sequential fetch
        step(); chk("addr4", imem_addr, 32'h4); chk("first_valid", {31'b0, id_valid}, 32'd1);
        chk("first_inst", id_inst, mem_word(32'h0));
        step(); chk("addr8", imem_addr, 32'h8);
        step(); chk("addr12", imem_addr, 32'hC); chk("id_pc8", id_pc, 32'h8);
        step(); chk("pc10", if_pc, 32'h10);

        // three stalled cycles
        stall = 1;
        repeat (3) begin
            step(); chk("stall_pc", if_pc, 32'h10); chk("stall_idpc", id_pc, 32'hC);
        end
        idle();
        step(); chk("unstall_pc", if_pc, 32'h14);

        // branch overriding stall
        stall = 1; br = 1; br_tgt = 32'h40;
        step(); chk("br_pc", if_pc, 32'h40); chk("br_bubble_v", {31'b0, id_valid}, 32'd0);
        chk("br_bubble_inst", id_inst, NOP);
        idle();
        step(); chk("br_idpc", id_pc, 32'h40); chk("br_idv", {31'b0, id_valid}, 32'd1);

        // all redirects at once: trap wins
        trap = 1; mret = 1; br = 1; trap_vec = 32'h100; mepc = 32'h200; br_tgt = 32'h300;
        step(); chk("prio_pc", if_pc, 32'h100);
        idle();

        // misaligned target, then trap away
        br = 1; br_tgt = 32'h42;
        step(); idle();
        step(); chk("mis_idpc", id_pc, 32'h42); chk("mis_flag", {31'b0, id_mis}, 32'd1);
        chk("mis_inst", id_inst, NOP); chk("mis_valid", {31'b0, id_valid}, 32'd1);
        trap = 1; trap_vec = 32'h80;
        step(); chk("trap_pc", if_pc, 32'h80); chk("trap_bubble", {31'b0, id_valid}, 32'd0);
        idle();

        // stall + flush without redirect
        step();
        stall = 1; flush = 1;
        step(); chk("sf_pc", if_pc, 32'h84); chk("sf_valid", {31'b0, id_valid}, 32'd0);
        idle();

        // wrap-around
        br = 1; br_tgt = 32'hFFFF_FFFC;
        step(); idle();
        step(); chk("wrap_pc", if_pc, 32'h0);
        step();

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_pc", if_pc, 32'h0); chk("arst_valid", {31'b0, id_valid}, 32'd0);
        chk("arst_inst", id_inst, NOP);
        @(posedge clk); #1;
        chk_model();
        rst_n = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            br       = ($urandom_range(0, 7) == 0);
            trap     = ($urandom_range(0, 15) == 0);
            mret     = ($urandom_range(0, 15) == 0);
            br_tgt   = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            trap_vec = $urandom & 32'hFFFF_FFFC;
            mepc     = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            step();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
